// File: rtl/temp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : temp_sequencer
//  Purpose  : Sequences one temperature evaluation per accepted start.
//             The module registers troom/tref/dt into an external comparison
//             datapath. After one settle cycle it samples the datapath flags.
//             It then drives the heater/cooler enables and enforces two
//             protections: a minimum on-time (dwell) and a dead band on
//             heat<->cool reversals.
//  Ports    : clk            - system clock, all state on rising edge
//             reset          - asynchronous, active-low reset
//             start          - evaluation request, sampled only while idle
//             troom/tref/dt  - room temp, reference, hysteresis band (7b)
//             datapath_in1..3- registered troom/tref/dt to the datapath
//             datapath_out   - flags: [0] too cold [1] too hot [2] in band
//                              [3] fault
//             h, c           - heater / cooler enables (registered)
//             busy, done     - evaluation in progress / completion pulse
//             held           - request suppressed by minimum on-time
//             err            - sticky fault, cleared by next accepted start
//  Revision : 1.0  initial release
// ============================================================================
module temp_sequencer #(
    parameter int MIN_ON = 8,   // minimum on-time in cycles, 1..255
    parameter int DEAD   = 2    // dead cycles on a reversal, 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] troom,
    input  logic [6:0] tref,
    input  logic [6:0] dt,
    output logic [6:0] datapath_in1,
    output logic [6:0] datapath_in2,
    output logic [6:0] datapath_in3,
    input  logic [3:0] datapath_out,
    output logic       h,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       held,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EVAL = 3'd2,
        S_DEAD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        M_OFF  = 2'd0,
        M_HEAT = 2'd1,
        M_COOL = 2'd2
    } mode_t;

    localparam logic [7:0] c_min_on  = 8'(MIN_ON);
    // The dead counter is loaded with DEAD-1 so that the DEAD state spans
    // exactly DEAD cycles, including the cycle in which it reaches zero.
    localparam logic [3:0] c_dead_m1 = 4'(DEAD - 1);

    state_t     state_q, state_d;
    mode_t      mode_q,  mode_d;
    mode_t      tgt_q,   tgt_d;      // destination mode held across DEAD
    logic [7:0] dwell_q, dwell_d;
    logic [3:0] dead_q,  dead_d;
    logic [6:0] din1_q,  din1_d;
    logic [6:0] din2_q,  din2_d;
    logic [6:0] din3_q,  din3_d;
    logic       h_q, h_d, c_q, c_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       held_q, held_d, err_q, err_d;

    mode_t      w_target;

    // Flag decode: too-cold wins over too-hot; in-band or no flag means off.
    always_comb begin
        w_target = M_OFF;
        if (datapath_out[0]) begin
            w_target = M_HEAT;
        end else if (datapath_out[1]) begin
            w_target = M_COOL;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tgt_d   = tgt_q;
        dead_d  = dead_q;
        din1_d  = din1_q;
        din2_d  = din2_q;
        din3_d  = din3_q;
        held_d  = held_q;
        err_d   = err_q;
        // Dwell runs freely in every state (including idle) and saturates.
        dwell_d = (dwell_q == 8'd0) ? 8'd0 : dwell_q - 8'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    din1_d  = troom;
                    din2_d  = tref;
                    din3_d  = dt;
                    err_d   = 1'b0;
                    held_d  = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = S_DONE;
                if (datapath_out[3]) begin
                    // Fault overrides dwell protection.
                    mode_d = M_OFF;
                    err_d  = 1'b1;
                end else if (w_target == mode_q) begin
                    mode_d = mode_q;
                end else if ((mode_q != M_OFF) && (dwell_q != 8'd0)) begin
                    held_d = 1'b1;
                end else if ((mode_q == M_OFF) || (w_target == M_OFF)) begin
                    mode_d = w_target;
                end else begin
                    // Reversal: go through OFF for DEAD cycles first.
                    mode_d  = M_OFF;
                    tgt_d   = w_target;
                    dead_d  = c_dead_m1;
                    state_d = S_DEAD;
                end
            end
            S_DEAD: begin
                if (dead_q == 4'd0) begin
                    mode_d  = tgt_q;
                    state_d = S_DONE;
                end else begin
                    dead_d = dead_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                mode_d  = M_OFF;
            end
        endcase

        // Any transition into HEAT or COOL restarts the minimum on-time.
        if ((mode_d != M_OFF) && (mode_d != mode_q)) begin
            dwell_d = c_min_on;
        end

        h_d    = (mode_d == M_HEAT);
        c_d    = (mode_d == M_COOL);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= M_OFF;
            tgt_q   <= M_OFF;
            dwell_q <= 8'd0;
            dead_q  <= 4'd0;
            din1_q  <= 7'd0;
            din2_q  <= 7'd0;
            din3_q  <= 7'd0;
            h_q     <= 1'b0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            held_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tgt_q   <= tgt_d;
            dwell_q <= dwell_d;
            dead_q  <= dead_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
            din3_q  <= din3_d;
            h_q     <= h_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            held_q  <= held_d;
            err_q   <= err_d;
        end
    end

    assign datapath_in1 = din1_q;
    assign datapath_in2 = din2_q;
    assign datapath_in3 = din3_q;
    assign h            = h_q;
    assign c            = c_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign held         = held_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: doc/temp_sequencer.md
TEMP_SEQUENCER -- requirements
Module: temp_sequencer

Interface
REQ-001 SHALL have parameter MIN_ON, default 8, minimum cycles h or c stays asserted once turned on (range 1..255).
REQ-002 SHALL have parameter DEAD, default 2, cycles with h=c=0 on a HEAT<->COOL reversal (range 1..15).
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one evaluation; sampled only while busy=0.
REQ-006 SHALL have ports troom, tref, dt  input  7 each  room temperature, reference, hysteresis band.
REQ-007 SHALL have ports datapath_in1, datapath_in2, datapath_in3  output  7 each  registered troom, tref, dt to the comparison datapath.
REQ-008 SHALL have port datapath_out  input  4  datapath flags: bit0 too-cold, bit1 too-hot, bit2 in-band, bit3 fault.
REQ-009 SHALL have ports h, c  output  1 each  heater / cooler enables, registered.
REQ-010 SHALL have ports busy, done, held, err  output  1 each  evaluation in progress, one-cycle completion pulse, request suppressed by MIN_ON, sticky fault.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, EVAL, DEAD, DONE and an actuator mode register OFF/HEAT/COOL driving h=(HEAT), c=(COOL).
REQ-012 IDLE: busy=0; start=1 at edge N SHALL latch troom/tref/dt into datapath_in1..3, clear err, and enter LOAD (busy=1 from N+1).
REQ-013 datapath_in1..3 SHALL change only on an accepted start; start while busy=1 SHALL be ignored with no other effect.
REQ-014 LOAD SHALL last exactly one cycle (datapath settle), then EVAL.
REQ-015 EVAL SHALL sample datapath_out once and derive target: bit3 -> fault; else bit0 -> HEAT; else bit1 -> COOL; else OFF (bit0 has priority over bit1).
REQ-016 Fault SHALL force mode OFF immediately, ignoring dwell, set err=1, go to DONE.
REQ-017 target equal to current mode SHALL leave mode unchanged, go to DONE.
REQ-018 Dwell counter (8 bits) SHALL load MIN_ON when mode enters HEAT or COOL, decrement by 1 per cycle, saturate at 0.
REQ-019 Non-fault target differing from current HEAT/COOL while dwell counter != 0 SHALL keep mode, set held=1, go to DONE.
REQ-020 OFF->HEAT/COOL, or HEAT/COOL->OFF with dwell=0, SHALL update mode on the EVAL exit edge and go to DONE.
REQ-021 HEAT->COOL or COOL->HEAT with dwell=0 SHALL set mode OFF on the EVAL exit edge, stay in DEAD exactly DEAD cycles, then set target mode on the DEAD exit edge and go to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE with busy=0; start accepted at N yields done at N+3 (no DEAD) or N+3+DEAD (reversal).
REQ-023 held SHALL be valid from DONE until the next accepted start clears it; err SHALL remain set until next accepted start.
REQ-024 h and c SHALL never both be 1 in any cycle, including during reversal.
REQ-025 Dwell counter SHALL keep counting while IDLE, so MIN_ON elapses in real time between evaluations.

Reset
REQ-026 reset=0 SHALL asynchronously force IDLE, mode OFF, h=c=0, busy=done=held=err=0, dwell=0, datapath_in1..3=0, in any state including mid-DEAD.
REQ-027 Release of reset SHALL make the first rising clk edge with reset=1 able to accept start.

Verification
REQ-028 Cold start: troom=20,tref=25,dt=2, datapath_out=4'b0001, start at N -> h=1,c=0 from N+3, done=1 only at N+3, busy low at N+4.
REQ-029 Dwell hold: after REQ-028, start at N+5 with datapath_out=4'b0100 (MIN_ON=8) -> h stays 1, held=1, done at N+8; repeat start after dwell expiry -> h=0, held=0.
REQ-030 Reversal: mode HEAT, dwell 0, datapath_out=4'b0010, DEAD=2, start at M -> h=0 at M+3, c=0 at M+3..M+4, c=1 and done=1 at M+5, never h=c=1.
REQ-031 Fault: mode COOL with dwell=5, datapath_out=4'b1010 -> c=0 at DONE, err=1 held until next start, held=0.
REQ-032 Busy and reset: start pulses during LOAD/EVAL/DEAD ignored (datapath_in1..3 unchanged); reset=0 asserted mid-DEAD -> all outputs 0 without clk edge.
